// File: rtl/beam_ctrl_pkg.sv
// Shared types and constants for the beam threshold load controller.
package beam_ctrl_pkg;

  typedef logic [17:0] thresh_t;

  // 31^2 * 256: largest threshold the beamformer power path can produce
  localparam int unsigned THRESH_MAX_C     = 246016;
  localparam int unsigned THRESH_DEFAULT_C = 246016;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UPDATE,
    SETTLE
  } ld_state_t;

endpackage

// File: rtl/dirty_prio_enc.sv
// Lowest-set-bit priority encoder over the dirty-beam vector.
module dirty_prio_enc #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Scan from the top down so the lowest requesting index is the one left standing
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/beam_thresh_loader.sv
// Shadow-register threshold loader: software writes land in per-beam shadows,
// a commit then walks the dirty beams over the shared thresh bus and pulses
// update for every pair that received a new value.
module beam_thresh_loader
  import beam_ctrl_pkg::*;
#(
  parameter int          NPAIR          = 2,
  parameter int          THRESH_BITS    = 18,
  parameter int unsigned THRESH_MAX     = THRESH_MAX_C,
  parameter int unsigned THRESH_DEFAULT = THRESH_DEFAULT_C
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [$clog2(2*NPAIR)-1:0]   wr_beam_i,
  input  logic [THRESH_BITS-1:0]       wr_thresh_i,
  input  logic                         commit_i,
  output logic [THRESH_BITS-1:0]       thresh_o,
  output logic [2*NPAIR-1:0]           thresh_ce_o,
  output logic [NPAIR-1:0]             update_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         sat_o
);

  localparam int NBEAM = 2 * NPAIR;
  localparam int IDXW  = $clog2(NBEAM);
  localparam logic [THRESH_BITS-1:0] MAX_V = THRESH_BITS'(THRESH_MAX);
  localparam logic [THRESH_BITS-1:0] DEF_V = THRESH_BITS'(THRESH_DEFAULT);

  ld_state_t                state_q, state_d;
  logic [THRESH_BITS-1:0]   shadow_q [NBEAM];
  logic [THRESH_BITS-1:0]   shadow_d [NBEAM];
  logic [NBEAM-1:0]         dirty_q, dirty_d;
  logic [NPAIR-1:0]         touched_q, touched_d;
  logic                     pending_q, pending_d;
  logic [THRESH_BITS-1:0]   thresh_q, thresh_d;
  logic [NBEAM-1:0]         ce_q, ce_d;
  logic [NPAIR-1:0]         update_q, update_d;
  logic                     done_q, done_d;
  logic                     sat_q, sat_d;

  logic [NBEAM-1:0]         wr_onehot;
  logic [NBEAM-1:0]         enc_req;
  logic [IDXW-1:0]          enc_idx;
  logic                     enc_any;
  logic [THRESH_BITS-1:0]   clamped;
  logic                     issue;

  // Decode an accepted write to a one-hot beam; out-of-range indices decode to nothing
  always_comb begin
    wr_onehot = '0;
    for (int b = 0; b < NBEAM; b++) begin
      if (wr_valid_i && (state_q == IDLE) && (wr_beam_i == IDXW'(b))) wr_onehot[b] = 1'b1;
    end
  end

  // A write in the same cycle as the commit must be visible to the first pick
  assign enc_req = dirty_q | wr_onehot;

  dirty_prio_enc #(
    .N    (NBEAM),
    .IDXW (IDXW)
  ) u_prio (
    .req (enc_req),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    dirty_d   = dirty_q | wr_onehot;
    touched_d = touched_q;
    pending_d = pending_q;
    thresh_d  = thresh_q;
    ce_d      = '0;
    update_d  = '0;
    done_d    = 1'b0;
    issue     = 1'b0;

    clamped = (wr_thresh_i > MAX_V) ? MAX_V : wr_thresh_i;
    for (int b = 0; b < NBEAM; b++) begin
      if (wr_onehot[b]) shadow_d[b] = clamped;
    end
    sat_d = (|wr_onehot) && (wr_thresh_i > MAX_V);

    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (commit_i || pending_q) begin
          touched_d = '0;
          if (enc_any) begin
            state_d = LOAD;
            issue   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        pending_d = pending_q | commit_i;
        if (enc_any) begin
          issue = 1'b1;
        end else begin
          state_d  = UPDATE;
          update_d = touched_q;
        end
      end
      UPDATE: begin
        pending_d = pending_q | commit_i;
        state_d   = SETTLE;
      end
      SETTLE: begin
        pending_d = pending_q | commit_i;
        state_d   = IDLE;
        done_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Beam 2p is the pair's A side, which sits on CE bit 2p+1, hence the index swap
    if (issue) begin
      for (int b = 0; b < NBEAM; b++) begin
        if (enc_idx == IDXW'(b)) begin
          thresh_d   = shadow_d[b];
          dirty_d[b] = 1'b0;
        end
        if (enc_idx == IDXW'(b ^ 1)) ce_d[b] = 1'b1;
      end
      for (int p = 0; p < NPAIR; p++) begin
        if ((enc_idx == IDXW'(2 * p)) || (enc_idx == IDXW'(2 * p + 1))) touched_d[p] = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      for (int b = 0; b < NBEAM; b++) shadow_q[b] <= DEF_V;
      dirty_q   <= '0;
      touched_q <= '0;
      pending_q <= 1'b0;
      thresh_q  <= '0;
      ce_q      <= '0;
      update_q  <= '0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      dirty_q   <= dirty_d;
      touched_q <= touched_d;
      pending_q <= pending_d;
      thresh_q  <= thresh_d;
      ce_q      <= ce_d;
      update_q  <= update_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
    end
  end

  assign thresh_o    = thresh_q;
  assign thresh_ce_o = ce_q;
  assign update_o    = update_q;
  assign done_o      = done_q;
  assign sat_o       = sat_q;
  assign busy_o      = (state_q != IDLE);
  assign wr_ready_o  = (state_q == IDLE);

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Self-checking bench for beam_thresh_loader against a timeline model of commits.
module tb_beam_thresh_loader;

  localparam int NBEAM = 4;
  localparam int TMAX  = 246016;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [1:0]  wr_beam_i;
  logic [17:0] wr_thresh_i;
  logic        commit_i;
  logic [17:0] thresh_o;
  logic [3:0]  thresh_ce_o;
  logic [1:0]  update_o;
  logic        busy_o;
  logic        done_o;
  logic        sat_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_shadow [NBEAM];
  bit m_dirty  [NBEAM];
  int m_last;

  always #5 clk = ~clk;

  beam_thresh_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_beam_i   (wr_beam_i),
    .wr_thresh_i (wr_thresh_i),
    .commit_i    (commit_i),
    .thresh_o    (thresh_o),
    .thresh_ce_o (thresh_ce_o),
    .update_o    (update_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sat_o       (sat_o)
  );

  task automatic model_reset();
    for (int b = 0; b < NBEAM; b++) begin
      m_shadow[b] = TMAX;
      m_dirty[b]  = 1'b0;
    end
    m_last = 0;
  endtask

  task automatic model_write(input int beam, input int val);
    m_shadow[beam] = (val > TMAX) ? TMAX : val;
    m_dirty[beam]  = 1'b1;
  endtask

  task automatic do_write(input int beam, input int val, input string tag);
    bit exp_sat;
    wr_valid_i  = 1'b1;
    wr_beam_i   = 2'(beam);
    wr_thresh_i = 18'(val);
    @(posedge clk); #1;
    wr_valid_i = 1'b0;
    exp_sat = (val > TMAX);
    model_write(beam, val);
    n_cmp++;
    if (sat_o !== exp_sat) begin
      n_bad++;
      $display("[TB] FAIL %s sat beam%0d val=%0d: got %b want %b", tag, beam, val, sat_o, exp_sat);
    end
  endtask

  // Issue a commit and check every cycle of the expected timeline against the model
  task automatic run_commit(input bit with_wr, input int wbeam, input int wval,
                            input bit busy_cmds, input string tag);
    int          list[$];
    logic [1:0]  mask;
    int          k;
    int          total;
    logic [3:0]  exp_ce;
    logic [1:0]  exp_upd;
    logic        exp_done;
    logic        exp_busy;
    logic [17:0] exp_thr;
    bit          exp_sat;

    commit_i = 1'b1;
    if (with_wr) begin
      wr_valid_i  = 1'b1;
      wr_beam_i   = 2'(wbeam);
      wr_thresh_i = 18'(wval);
    end
    @(posedge clk); #1;
    commit_i   = 1'b0;
    wr_valid_i = 1'b0;
    if (with_wr) begin
      exp_sat = (wval > TMAX);
      model_write(wbeam, wval);
      n_cmp++;
      if (sat_o !== exp_sat) begin
        n_bad++;
        $display("[TB] FAIL %s sat on commit write: got %b want %b", tag, sat_o, exp_sat);
      end
    end

    mask = '0;
    for (int b = 0; b < NBEAM; b++) begin
      if (m_dirty[b]) begin
        list.push_back(b);
        mask = mask | 2'(1 << (b / 2));
        m_dirty[b] = 1'b0;
      end
    end
    k = list.size();
    total = (k == 0) ? 1 : (k + 3 + (busy_cmds ? 1 : 0));

    for (int j = 1; j <= total + 1; j++) begin
      if (k == 0) begin
        exp_ce   = '0;
        exp_upd  = '0;
        exp_done = (j == 1);
        exp_busy = 1'b0;
      end else begin
        exp_ce   = (j <= k) ? 4'(1 << (list[j-1] ^ 1)) : 4'b0;
        if (j <= k) m_last = m_shadow[list[j-1]];
        exp_upd  = (j == k + 1) ? mask : 2'b0;
        exp_done = (j == k + 3) || (busy_cmds && (j == k + 4));
        exp_busy = (j <= k + 2);
      end
      exp_thr = 18'(m_last);
      n_cmp++;
      if ({thresh_ce_o, update_o, done_o, busy_o, wr_ready_o, thresh_o} !==
          {exp_ce, exp_upd, exp_done, exp_busy, ~exp_busy, exp_thr}) begin
        n_bad++;
        $display("[TB] FAIL %s cycle %0d: ce=%b upd=%b done=%b busy=%b rdy=%b thr=%0d, want ce=%b upd=%b done=%b busy=%b rdy=%b thr=%0d",
                 tag, j, thresh_ce_o, update_o, done_o, busy_o, wr_ready_o, thresh_o,
                 exp_ce, exp_upd, exp_done, exp_busy, ~exp_busy, exp_thr);
      end
      commit_i = busy_cmds && (j == 1 || j == 2);
      if (j <= total) begin
        @(posedge clk); #1;
      end
    end
    commit_i = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_ni      = 1'b0;
    wr_valid_i  = 1'b0;
    wr_beam_i   = '0;
    wr_thresh_i = '0;
    commit_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if ({thresh_ce_o, update_o, done_o, busy_o, sat_o, wr_ready_o, thresh_o} !== {4'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0}) begin
      n_bad++;
      $display("[TB] FAIL reset outputs: ce=%b upd=%b done=%b busy=%b sat=%b rdy=%b thr=%0d, want all 0 with rdy=1",
               thresh_ce_o, update_o, done_o, busy_o, sat_o, wr_ready_o, thresh_o);
    end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    run_commit(1'b0, 0, 0, 1'b0, "empty_commit");
  endtask

  task automatic test_basic_load();
    $display("[TB] test_basic_load");
    do_write(0, 256, "basic");
    do_write(1, 255, "basic");
    run_commit(1'b0, 0, 0, 1'b0, "basic");
  endtask

  task automatic test_saturation();
    $display("[TB] test_saturation");
    do_write(3, 250000, "sat_over");
    run_commit(1'b0, 0, 0, 1'b0, "sat_commit");
    do_write(2, TMAX, "sat_edge_eq");
    do_write(3, TMAX + 1, "sat_edge_plus1");
    do_write(1, 262143, "sat_full_scale");
    run_commit(1'b0, 0, 0, 1'b0, "sat_edge_commit");
  endtask

  task automatic test_busy_commit();
    $display("[TB] test_busy_commit");
    do_write(1, int'($urandom_range(0, 200000)), "busy");
    do_write(2, int'($urandom_range(0, 200000)), "busy");
    run_commit(1'b0, 0, 0, 1'b1, "busy_commit");
  endtask

  task automatic test_same_cycle();
    $display("[TB] test_same_cycle");
    run_commit(1'b1, 2, 17, 1'b0, "same_cycle");
  endtask

  task automatic test_reset_mid_load();
    $display("[TB] test_reset_mid_load");
    do_write(0, int'($urandom_range(0, 200000)), "midrst");
    do_write(3, int'($urandom_range(0, 200000)), "midrst");
    commit_i = 1'b1;
    @(posedge clk); #1;
    commit_i = 1'b0;
    rst_ni   = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    model_reset();
    n_cmp++;
    if ({thresh_ce_o, update_o, done_o, busy_o, sat_o, wr_ready_o, thresh_o} !== {4'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0}) begin
      n_bad++;
      $display("[TB] FAIL midrst outputs: ce=%b upd=%b done=%b busy=%b sat=%b rdy=%b thr=%0d, want all 0 with rdy=1",
               thresh_ce_o, update_o, done_o, busy_o, sat_o, wr_ready_o, thresh_o);
    end
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({thresh_ce_o, update_o, done_o, busy_o} !== 8'b0) begin
        n_bad++;
        $display("[TB] FAIL midrst quiet cycle %0d: ce=%b upd=%b done=%b busy=%b, want all 0",
                 j, thresh_ce_o, update_o, done_o, busy_o);
      end
    end
    run_commit(1'b0, 0, 0, 1'b0, "midrst_empty");
  endtask

  task automatic test_random();
    int nw;
    int val;
    $display("[TB] test_random");
    for (int it = 0; it < 12; it++) begin
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 1) == 1) val = int'($urandom_range(240000, 262143));
        else                           val = int'($urandom_range(0, 262143));
        do_write(int'($urandom_range(0, 3)), val, "rand");
      end
      if ($urandom_range(0, 1) == 1)
        run_commit(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 262143)),
                   1'b0, "rand_commit_wr");
      else
        run_commit(1'b0, 0, 0, ($urandom_range(0, 3) == 0) && (nw > 0), "rand_commit");
    end
  endtask

  // Scenario sequence, then the one-line summary
  initial begin
    test_reset();
    test_basic_load();
    test_saturation();
    test_busy_commit();
    test_same_cycle();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
